// File: rtl/prim_hw2sw_fifo_reg.sv
// Hardware-to-software register slice: HW pushes words into a small FIFO and SW drains it
// through a read-to-pop data register, with level, sticky error flags and a threshold interrupt.
module prim_hw2sw_fifo_reg #(
  parameter int DW    = 32,
  parameter int Depth = 4,
  parameter int LW    = $clog2(Depth + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,

  input  logic          hw_valid_i,
  input  logic [DW-1:0] hw_data_i,
  output logic          hw_ready_o,

  input  logic          re,
  output logic [DW-1:0] qs,

  output logic [LW-1:0] level_o,
  output logic          full_o,
  output logic          empty_o,

  input  logic          err_we,
  input  logic [1:0]    err_wd,
  output logic          ovf_o,
  output logic          udf_o,

  input  logic          thresh_we,
  input  logic [LW-1:0] thresh_wd,
  output logic [LW-1:0] thresh_o,
  output logic          intr_o
);

  localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(Depth - 1);
  localparam logic [LW-1:0] DEPTH_L  = LW'(Depth);
  localparam logic [LW-1:0] ONE_L    = LW'(1);

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PW'(1);
  endfunction

  function automatic logic [LW-1:0] sat_thresh(input logic [LW-1:0] v);
    return (v > DEPTH_L) ? DEPTH_L : v;
  endfunction

  logic [DW-1:0] mem [Depth];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] level_q, level_nxt;
  logic [LW-1:0] thresh_q;
  logic          ovf_q, udf_q, intr_q;
  logic          full, empty;
  logic          push, pop;
  logic          ovf_set, udf_set;
  logic          intr_nxt;

  // Status derives from registered level only, so ready has no path from re.
  assign full    = (level_q == DEPTH_L);
  assign empty   = (level_q == '0);
  assign push    = hw_valid_i && !full;
  assign pop     = re && !empty;
  assign ovf_set = hw_valid_i && full;
  assign udf_set = re && empty;

  always_comb begin
    level_nxt = level_q;
    if (push && !pop) begin
      level_nxt = level_q + ONE_L;
    end else if (pop && !push) begin
      level_nxt = level_q - ONE_L;
    end
  end

  // Interrupt uses the post-update level against the threshold already in place.
  assign intr_nxt = (thresh_q != '0) && (level_nxt >= thresh_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      thresh_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      intr_q   <= 1'b0;
    end else begin
      if (push) begin
        wptr_q <= next_ptr(wptr_q);
      end
      if (pop) begin
        rptr_q <= next_ptr(rptr_q);
      end
      level_q <= level_nxt;
      if (thresh_we) begin
        thresh_q <= sat_thresh(thresh_wd);
      end
      // Set takes priority over a same-cycle W1C clear.
      ovf_q  <= ovf_set | (ovf_q & ~(err_we & err_wd[0]));
      udf_q  <= udf_set | (udf_q & ~(err_we & err_wd[1]));
      intr_q <= intr_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wptr_q] <= hw_data_i;
    end
  end

  assign hw_ready_o = !full;
  assign qs         = empty ? '0 : mem[rptr_q];
  assign level_o    = level_q;
  assign full_o     = full;
  assign empty_o    = empty;
  assign ovf_o      = ovf_q;
  assign udf_o      = udf_q;
  assign thresh_o   = thresh_q;
  assign intr_o     = intr_q;

endmodule

// File: tb/tb_prim_hw2sw_fifo_reg.sv
// Directed bench for prim_hw2sw_fifo_reg at DW=32, Depth=4 with hand-computed expectations.
module tb_prim_hw2sw_fifo_reg;

  localparam int DW    = 32;
  localparam int Depth = 4;
  localparam int LW    = $clog2(Depth + 1);

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          hw_valid_i;
  logic [DW-1:0] hw_data_i;
  logic          hw_ready_o;
  logic          re;
  logic [DW-1:0] qs;
  logic [LW-1:0] level_o;
  logic          full_o, empty_o;
  logic          err_we;
  logic [1:0]    err_wd;
  logic          ovf_o, udf_o;
  logic          thresh_we;
  logic [LW-1:0] thresh_wd;
  logic [LW-1:0] thresh_o;
  logic          intr_o;

  int n_cmp = 0;
  int n_err = 0;

  prim_hw2sw_fifo_reg #(.DW(DW), .Depth(Depth)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .hw_valid_i (hw_valid_i),
    .hw_data_i  (hw_data_i),
    .hw_ready_o (hw_ready_o),
    .re         (re),
    .qs         (qs),
    .level_o    (level_o),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .err_we     (err_we),
    .err_wd     (err_wd),
    .ovf_o      (ovf_o),
    .udf_o      (udf_o),
    .thresh_we  (thresh_we),
    .thresh_wd  (thresh_wd),
    .thresh_o   (thresh_o),
    .intr_o     (intr_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    hw_valid_i = 1'b1;
    hw_data_i  = d;
    step();
    hw_valid_i = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [31:0] exp);
    re = 1'b1;
    #1;
    check(tag, qs, exp);
    step();
    re = 1'b0;
  endtask

  task automatic set_thresh(input logic [LW-1:0] v);
    thresh_we = 1'b1;
    thresh_wd = v;
    step();
    thresh_we = 1'b0;
  endtask

  task automatic clear_err(input logic [1:0] wd);
    err_we = 1'b1;
    err_wd = wd;
    step();
    err_we = 1'b0;
    err_wd = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_ni = 1'b0; hw_valid_i = 1'b0; hw_data_i = '0; re = 1'b0;
    err_we = 1'b0; err_wd = 2'b00; thresh_we = 1'b0; thresh_wd = '0;
    step(); step();
    rst_ni = 1'b1;
    step();

    // Reset and idle
    check("rst_level", 32'(level_o), 0);
    check("rst_empty", 32'(empty_o), 1);
    check("rst_full", 32'(full_o), 0);
    check("rst_ready", 32'(hw_ready_o), 1);
    check("rst_qs", qs, 0);
    check("rst_ovf", 32'(ovf_o), 0);
    check("rst_udf", 32'(udf_o), 0);
    check("rst_thresh", 32'(thresh_o), 0);
    check("rst_intr", 32'(intr_o), 0);

    // Fill to full, then overflow
    push(32'hA1); push(32'hA2); push(32'hA3); push(32'hA4);
    check("fill_full", 32'(full_o), 1);
    check("fill_ready", 32'(hw_ready_o), 0);
    check("fill_level", 32'(level_o), 4);
    check("fill_head", qs, 32'hA1);
    push(32'hA5);
    check("ovf_set", 32'(ovf_o), 1);
    check("ovf_level", 32'(level_o), 4);
    clear_err(2'b01);
    check("ovf_clr", 32'(ovf_o), 0);

    // Drain in order
    pop_check("drain0", 32'hA1);
    pop_check("drain1", 32'hA2);
    pop_check("drain2", 32'hA3);
    pop_check("drain3", 32'hA4);
    check("drain_empty", 32'(empty_o), 1);
    check("drain_level", 32'(level_o), 0);
    check("drain_qs", qs, 0);
    check("drain_udf", 32'(udf_o), 0);

    // Streaming at level 2 across pointer wrap
    push(32'hB0); push(32'hB1);
    for (int i = 0; i < 10; i++) begin
      hw_valid_i = 1'b1;
      hw_data_i  = 32'hB2 + 32'(i);
      re         = 1'b1;
      #1;
      check($sformatf("stream_qs%0d", i), qs, 32'hB0 + 32'(i));
      step();
      check($sformatf("stream_lvl%0d", i), 32'(level_o), 2);
    end
    hw_valid_i = 1'b0;
    re = 1'b0;
    pop_check("stream_tail0", 32'hBA);
    pop_check("stream_tail1", 32'hBB);
    check("stream_empty", 32'(empty_o), 1);

    // Underflow, W1C, set-wins
    pop_check("udf_qs", 32'h0);
    check("udf_set", 32'(udf_o), 1);
    check("udf_level", 32'(level_o), 0);
    clear_err(2'b10);
    check("udf_clr", 32'(udf_o), 0);
    re = 1'b1; err_we = 1'b1; err_wd = 2'b10;
    step();
    re = 1'b0; err_we = 1'b0; err_wd = 2'b00;
    check("udf_setwins", 32'(udf_o), 1);
    clear_err(2'b10);
    check("udf_clr2", 32'(udf_o), 0);

    // Threshold interrupt
    set_thresh(3'd3);
    check("thr_val", 32'(thresh_o), 3);
    push(32'hC1);
    check("thr_intr1", 32'(intr_o), 0);
    push(32'hC2);
    check("thr_intr2", 32'(intr_o), 0);
    push(32'hC3);
    check("thr_intr3", 32'(intr_o), 1);
    check("thr_level3", 32'(level_o), 3);
    pop_check("thr_pop", 32'hC1);
    check("thr_intr_off", 32'(intr_o), 0);
    set_thresh(3'd7);
    check("thr_sat", 32'(thresh_o), 4);
    check("thr_intr_sat", 32'(intr_o), 0);
    set_thresh(3'd0);

    // Full with simultaneous push and pop
    push(32'hD1); push(32'hD2);
    check("fpp_full", 32'(full_o), 1);
    hw_valid_i = 1'b1; hw_data_i = 32'hEE; re = 1'b1;
    #1;
    check("fpp_ready", 32'(hw_ready_o), 0);
    check("fpp_qs", qs, 32'hC2);
    step();
    hw_valid_i = 1'b0; re = 1'b0;
    check("fpp_ovf", 32'(ovf_o), 1);
    check("fpp_level", 32'(level_o), 3);
    pop_check("fpp_d0", 32'hC3);
    pop_check("fpp_d1", 32'hD1);
    pop_check("fpp_d2", 32'hD2);
    check("fpp_empty", 32'(empty_o), 1);
    clear_err(2'b01);

    // Asynchronous reset mid-traffic
    set_thresh(3'd2);
    push(32'hE1); push(32'hE2); push(32'hE3);
    check("mrst_pre_level", 32'(level_o), 3);
    check("mrst_pre_intr", 32'(intr_o), 1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("mrst_level", 32'(level_o), 0);
    check("mrst_empty", 32'(empty_o), 1);
    check("mrst_ready", 32'(hw_ready_o), 1);
    check("mrst_qs", qs, 0);
    check("mrst_thresh", 32'(thresh_o), 0);
    check("mrst_intr", 32'(intr_o), 0);
    step();
    rst_ni = 1'b1;
    step();
    push(32'hF1);
    check("post_rst_qs", qs, 32'hF1);
    check("post_rst_level", 32'(level_o), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/prim_hw2sw_fifo_reg.md
Name: prim_hw2sw_fifo_reg

Overview:
- Hardware-to-software register slice. Hardware pushes data words into a small FIFO, and software drains them through a read-to-pop data register.
- It is the reverse direction of the SW-written subreg: HW is the producer and the register-bus read path is the consumer.
- Also exposes level, full, empty, sticky overflow/underflow and a threshold interrupt.
- Instantiated inside peripheral register tops (e.g. SPI RX data) beside ordinary subregs.

Parameters:
- DW, 32, data word width.
- Depth, 4, FIFO entries; legal range 2..16, need not be a power of two.
- LW, $clog2(Depth+1), level/threshold width; derived, do not override.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- hw_valid_i  in  1  HW push request
- hw_data_i  in  DW  HW push data
- hw_ready_o  out  1  FIFO can accept; equals !full
- re  in  1  SW read pulse on data register; pops the head
- qs  out  DW  head entry for register read; '0 when empty
- level_o  out  LW  number of valid entries
- full_o  out  1  level == Depth
- empty_o  out  1  level == 0
- err_we  in  1  SW write strobe to error-status register
- err_wd  in  2  write data; W1C: bit0 clears ovf, bit1 clears udf
- ovf_o  out  1  sticky: push attempted while full
- udf_o  out  1  sticky: read pulse while empty
- thresh_we  in  1  SW write strobe to threshold register
- thresh_wd  in  LW  threshold value
- thresh_o  out  LW  current threshold
- intr_o  out  1  registered threshold interrupt

Behaviour:
- Reset (async assert, sync deassert by integrator): pointers=0, level_o=0, empty_o=1, full_o=0, hw_ready_o=1, qs='0, ovf_o=0, udf_o=0, thresh_o=0, intr_o=0. Storage contents are not reset, but qs is masked to '0 while empty.
- Reset mid-operation discards all entries immediately; no partial state survives.

Push and pop:
- Push accepted when hw_valid_i && hw_ready_o. The entry is written at the write pointer on that clk edge, and the write pointer advances.
- Pointer wrap: Depth-1 -> 0, explicit compare, no power-of-two reliance.
- Push when full (hw_valid_i && !hw_ready_o): data dropped, ovf_o set next cycle, FIFO unchanged.
- Pop when re && !empty_o: the read pointer advances at the edge.
- qs is combinational from the current head; the value read in the re cycle is the popped word (read-before-pop).
- re when empty: no pointer change, qs='0, udf_o set next cycle.
- Simultaneous accepted push and pop: level unchanged, both pointers advance. When level==0, the pushed word is not readable that cycle (no bypass).
- Full blocks a push even if re pops in the same cycle. hw_ready_o depends only on registered state, with no combinational path from re.
- Write-to-read latency: a word pushed at edge N is visible on qs after edge N.
- level_o is registered and updated by +1/-1/0 per cycle; it never exceeds Depth and never underflows.

Sticky flags:
- ovf/udf are set by events and cleared by err_we with the matching err_wd bit.
- If set and clear occur in the same cycle, set wins (flag stays 1).

Threshold interrupt:
- thresh_o loads thresh_wd on thresh_we. Values > Depth are saturated to Depth.
- intr_o is registered: next intr_o = (thresh_o != 0) && (next level >= thresh_o), evaluated on post-update values, so it asserts the cycle after the push that crosses the threshold.
- intr_o is level-type: it deasserts the cycle after pops bring level below thresh_o.
- thresh_o == 0 disables the interrupt.
- A threshold write takes effect on intr_o one cycle after it lands.

Test Plan:
- Reset then idle -> level_o=0, empty_o=1, hw_ready_o=1, qs=0, intr_o=0. Assert rst_ni low mid-traffic with level=3 -> all outputs return to reset values asynchronously.
- Push 0xA1,0xA2,0xA3,0xA4 (Depth=4) -> full_o=1, hw_ready_o=0, level_o=4. Push 0xA5 -> ovf_o=1, level stays 4. Four re pulses -> qs reads A1,A2,A3,A4 in order, then empty.
- Fill/drain 10 words continuously with push and re in the same cycles from level=2 -> level constant 2, ordering preserved across pointer wrap.
- re on empty -> qs=0, udf_o=1. err_we with err_wd=2'b10 -> udf_o=0. Clear and new underflow in the same cycle -> udf_o stays 1.
- thresh=3: push 2 words -> intr_o=0; third push -> intr_o=1 one cycle later; one re -> intr_o=0. Write thresh=7 -> thresh_o reads 4.
- Full FIFO with push and re in the same cycle -> pushed word dropped, ovf_o=1, level 3.
